// File: rtl/fwd_ctrl_unit.sv
// Operand-forwarding select generator with load-use stall detection for a 5-stage pipeline.
// Optional FWD_STALL_CNT_EN adds a saturating 16-bit load-use stall counter (o_stall_cnt).
module fwd_ctrl_unit #(
  parameter int unsigned AWIDTH = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_hold,
  input  logic              i_flush,
  input  logic              i_id_valid,
  input  logic [AWIDTH-1:0] i_id_rs,
  input  logic [AWIDTH-1:0] i_id_rt,
  input  logic              i_id_uses_rs,
  input  logic              i_id_uses_rt,
  input  logic [AWIDTH-1:0] i_id_rd,
  input  logic              i_id_regwrite,
  input  logic              i_id_memread,
  output logic [1:0]        o_forward_a,
  output logic [1:0]        o_forward_b,
  output logic              o_stall,
  output logic              o_ex_valid
`ifdef FWD_STALL_CNT_EN
  ,
  output logic [15:0]       o_stall_cnt
`endif
);

  // WB-stage producers are never forwarded (write-first register file), so only EX and MEM
  // destinations are shadowed.
  logic [AWIDTH-1:0] ex_rd_q, ex_rd_d, mem_rd_q, mem_rd_d;
  logic              ex_we_q, ex_we_d, ex_mr_q, ex_mr_d, ex_valid_q, ex_valid_d;
  logic              mem_we_q, mem_we_d;
  logic [1:0]        fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
  logic [1:0]        nxt_a, nxt_b;
  logic              ex_we_eff, mem_we_eff, stall_raw;

  assign ex_we_eff  = ex_we_q && (ex_rd_q != '0);
  assign mem_we_eff = mem_we_q && (mem_rd_q != '0);

  assign stall_raw = i_id_valid && ex_mr_q && ex_we_eff &&
                     ((i_id_uses_rs && (i_id_rs == ex_rd_q)) ||
                      (i_id_uses_rt && (i_id_rt == ex_rd_q)));
  assign o_stall   = stall_raw && !i_hold;

  // EX match is checked first so the youngest producer wins.
  always_comb begin
    nxt_a = 2'd0;
    if (i_id_uses_rs && ex_we_eff && (i_id_rs == ex_rd_q)) begin
      nxt_a = 2'd1;
    end else if (i_id_uses_rs && mem_we_eff && (i_id_rs == mem_rd_q)) begin
      nxt_a = 2'd2;
    end
    nxt_b = 2'd0;
    if (i_id_uses_rt && ex_we_eff && (i_id_rt == ex_rd_q)) begin
      nxt_b = 2'd1;
    end else if (i_id_uses_rt && mem_we_eff && (i_id_rt == mem_rd_q)) begin
      nxt_b = 2'd2;
    end
  end

  always_comb begin
    ex_rd_d    = ex_rd_q;
    ex_we_d    = ex_we_q;
    ex_mr_d    = ex_mr_q;
    ex_valid_d = ex_valid_q;
    mem_rd_d   = mem_rd_q;
    mem_we_d   = mem_we_q;
    fwd_a_d    = fwd_a_q;
    fwd_b_d    = fwd_b_q;
    if (!i_hold) begin
      mem_rd_d = ex_rd_q;
      mem_we_d = ex_we_q;
      if (i_flush || stall_raw) begin
        ex_rd_d    = '0;
        ex_we_d    = 1'b0;
        ex_mr_d    = 1'b0;
        ex_valid_d = 1'b0;
        fwd_a_d    = 2'd0;
        fwd_b_d    = 2'd0;
      end else begin
        ex_rd_d    = i_id_valid ? i_id_rd : '0;
        ex_we_d    = i_id_valid && i_id_regwrite;
        ex_mr_d    = i_id_valid && i_id_memread;
        ex_valid_d = i_id_valid;
        fwd_a_d    = nxt_a;
        fwd_b_d    = nxt_b;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_rd_q    <= '0;
      ex_we_q    <= 1'b0;
      ex_mr_q    <= 1'b0;
      ex_valid_q <= 1'b0;
      mem_rd_q   <= '0;
      mem_we_q   <= 1'b0;
      fwd_a_q    <= 2'd0;
      fwd_b_q    <= 2'd0;
    end else begin
      ex_rd_q    <= ex_rd_d;
      ex_we_q    <= ex_we_d;
      ex_mr_q    <= ex_mr_d;
      ex_valid_q <= ex_valid_d;
      mem_rd_q   <= mem_rd_d;
      mem_we_q   <= mem_we_d;
      fwd_a_q    <= fwd_a_d;
      fwd_b_q    <= fwd_b_d;
    end
  end

  assign o_forward_a = fwd_a_q;
  assign o_forward_b = fwd_b_q;
  assign o_ex_valid  = ex_valid_q;

`ifdef FWD_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (o_stall && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= 16'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign o_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fwd_ctrl_unit.sv
// Table-driven, scoreboard-checked bench for fwd_ctrl_unit: forwarding distances, load-use
// stall, zero register, hold, flush and asynchronous reset.
module tb_fwd_ctrl_unit;

  localparam int unsigned AW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_hold, i_flush, i_id_valid;
  logic [AW-1:0] i_id_rs, i_id_rt, i_id_rd;
  logic          i_id_uses_rs, i_id_uses_rt, i_id_regwrite, i_id_memread;
  logic [1:0]    o_forward_a, o_forward_b;
  logic          o_stall, o_ex_valid;
`ifdef FWD_STALL_CNT_EN
  logic [15:0]   o_stall_cnt;
`endif

  fwd_ctrl_unit #(.AWIDTH(AW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_hold       (i_hold),
    .i_flush      (i_flush),
    .i_id_valid   (i_id_valid),
    .i_id_rs      (i_id_rs),
    .i_id_rt      (i_id_rt),
    .i_id_uses_rs (i_id_uses_rs),
    .i_id_uses_rt (i_id_uses_rt),
    .i_id_rd      (i_id_rd),
    .i_id_regwrite(i_id_regwrite),
    .i_id_memread (i_id_memread),
    .o_forward_a  (o_forward_a),
    .o_forward_b  (o_forward_b),
    .o_stall      (o_stall),
    .o_ex_valid   (o_ex_valid)
`ifdef FWD_STALL_CNT_EN
    ,
    .o_stall_cnt  (o_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          hold, flush, valid;
    logic [AW-1:0] rs, rt, rd;
    bit          urs, urt, rw, mr;
    bit          st;
    logic [1:0]  a, b;
    bit          ev;
  } vec_t;

  typedef struct {
    int         idx;
    logic [1:0] a, b;
    bit         ev;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  function automatic vec_t mk(bit h, bit f, bit vld, int rs, int rt, bit urs, bit urt,
                              int rd, bit rw, bit mr, bit st, int a, int b, bit ev);
    vec_t v;
    v.hold = h;  v.flush = f;  v.valid = vld;
    v.rs = AW'(rs);  v.rt = AW'(rt);  v.rd = AW'(rd);
    v.urs = urs;  v.urt = urt;  v.rw = rw;  v.mr = mr;
    v.st = st;  v.a = 2'(a);  v.b = 2'(b);  v.ev = ev;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    i_hold = v.hold;  i_flush = v.flush;  i_id_valid = v.valid;
    i_id_rs = v.rs;  i_id_rt = v.rt;  i_id_rd = v.rd;
    i_id_uses_rs = v.urs;  i_id_uses_rt = v.urt;
    i_id_regwrite = v.rw;  i_id_memread = v.mr;
  endtask

  task automatic idle();
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  initial begin
    exp_t e;
    // Columns: hold flush valid rs rt urs urt rd rw mr | stall a b ex_valid (a/b/ev after edge)
    // Distance 1
    tbl.push_back(mk(0, 0, 1,  0,  0, 0, 0,  3, 1, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 1,  3,  4, 1, 1,  0, 0, 0, 0, 1, 0, 1));
    // Distance 2 through a NOP
    tbl.push_back(mk(0, 0, 1,  0,  0, 0, 0,  5, 1, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0,  0,  0, 0, 0,  0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1,  1,  5, 1, 1,  0, 0, 0, 0, 0, 2, 1));
    // Two producers of r5: youngest wins
    tbl.push_back(mk(0, 0, 1,  0,  0, 0, 0,  5, 1, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 1,  0,  0, 0, 0,  5, 1, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 1,  5,  5, 1, 1,  0, 0, 0, 0, 1, 1, 1));
    // Load-use on r7: one stall, then MEM forward
    tbl.push_back(mk(0, 0, 1,  0,  0, 0, 0,  7, 1, 1, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 1,  7,  2, 1, 1,  0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1,  7,  2, 1, 1,  0, 0, 0, 0, 2, 0, 1));
    // Load to r0, then read r0
    tbl.push_back(mk(0, 0, 1,  0,  0, 0, 0,  0, 1, 1, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 1,  0,  0, 1, 1,  0, 0, 0, 0, 0, 0, 1));
    // Hold 3 cycles between producer and consumer
    tbl.push_back(mk(0, 0, 1,  0,  0, 0, 0,  9, 1, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 0, 1,  9,  0, 1, 0,  0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 0, 1,  9,  0, 1, 0,  0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 0, 1,  9,  0, 1, 0,  0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 1,  9,  0, 1, 0,  0, 0, 0, 0, 1, 0, 1));
    // Hold freezes nonzero codes; MEM still holds r9 afterwards
    tbl.push_back(mk(1, 0, 1,  1,  1, 1, 1,  0, 0, 0, 0, 1, 0, 1));
    tbl.push_back(mk(0, 0, 1,  0,  9, 0, 1,  0, 0, 0, 0, 0, 2, 1));
    // Flush the consumer; MEM keeps advancing
    tbl.push_back(mk(0, 0, 1,  0,  0, 0, 0, 11, 1, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 1, 1, 11,  0, 1, 0,  0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 11,  0, 1, 0,  0, 0, 0, 0, 2, 0, 1));
    // Flush together with a load-use stall
    tbl.push_back(mk(0, 0, 1,  0,  0, 0, 0, 12, 1, 1, 0, 0, 0, 1));
    tbl.push_back(mk(0, 1, 1, 12,  0, 1, 0,  0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1,  0, 12, 0, 1,  0, 0, 0, 0, 0, 2, 1));
    // Hold masks the stall; it fires after release
    tbl.push_back(mk(0, 0, 1,  0,  0, 0, 0, 13, 1, 1, 0, 0, 0, 1));
    tbl.push_back(mk(1, 0, 1, 13,  0, 1, 0,  0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 1, 13,  0, 1, 0,  0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 13,  0, 1, 0,  0, 0, 0, 0, 2, 0, 1));

    // Reset and reset-state check
    idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset_fwd_a", o_forward_a, 0);
    check("reset_fwd_b", o_forward_b, 0);
    check("reset_stall", o_stall, 0);
    check("reset_ex_valid", o_ex_valid, 0);

    // Asynchronous reset mid-stream with a nonzero code and a pending stall
    @(negedge clk);
    drive(mk(0, 0, 1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0, 0));
    @(negedge clk);
    drive(mk(0, 0, 1, 3, 0, 1, 0, 7, 1, 1, 0, 0, 0, 0));
    @(negedge clk);
    drive(mk(0, 0, 1, 7, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    #1;
    check("pre_reset_fwd_a", o_forward_a, 1);
    check("pre_reset_stall", o_stall, 1);
    rst_n = 1'b0;
    #1;
    check("async_reset_fwd_a", o_forward_a, 0);
    check("async_reset_stall", o_stall, 0);
    check("async_reset_ex_valid", o_ex_valid, 0);
    idle();
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      drive(tbl[i]);
      #1;
      check($sformatf("v%0d_stall", i), o_stall, tbl[i].st);
      e.idx = i;  e.a = tbl[i].a;  e.b = tbl[i].b;  e.ev = tbl[i].ev;
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        check("scoreboard_underflow", 0, 1);
      end else begin
        e = sb.pop_front();
        check($sformatf("v%0d_fwd_a", e.idx), o_forward_a, e.a);
        check($sformatf("v%0d_fwd_b", e.idx), o_forward_b, e.b);
        check($sformatf("v%0d_ex_valid", e.idx), o_ex_valid, e.ev);
      end
    end
    check("scoreboard_drained", sb.size(), 0);

`ifdef FWD_STALL_CNT_EN
    // Stalls in the table: r7 load-use, r12 (with flush), r13 after hold release
    check("stall_cnt", o_stall_cnt, 3);
`endif

    @(negedge clk);
    idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
